// File: rtl/chess_pkg.sv
// Shared definitions for the move-generation datapath: piece/colour/column
// codes, the move word width and the arbiter state encoding.
package chess_pkg;

  localparam int NCOL        = 8;
  localparam int MW          = 160;
  localparam int GEN_TIMEOUT = 64;

  // All-zero move word, used as the idle/reset value of the move register.
  localparam logic [MW-1:0] PVOID = '0;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } colour_t;

  typedef enum logic [2:0] {
    COLA = 3'd0, COLB = 3'd1, COLC = 3'd2, COLD = 3'd3,
    COLE = 3'd4, COLF = 3'd5, COLG = 3'd6, COLH = 3'd7
  } col_t;

  // Arbiter states, kept as plain constants so older tooling can read them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_GEN    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker over 8 requesters: returns the first requesting index
// at or after ptr, wrapping 7 -> 0.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       grant_valid,
  output logic [2:0] grant
);

  logic [2:0] idx;

  // Scan the 8 positions in priority order starting at ptr.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant_valid = 1'b0;
    grant       = ptr;
    idx         = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

endmodule

// File: rtl/move_stream_arbiter.sv
// Runs one move-generation pass over the 8 column units, then drains their
// move FIFOs round-robin into a single tagged valid/ready move stream.
module move_stream_arbiter
  import chess_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 col_reset,
  input  logic [NCOL-1:0]      col_done,
  input  logic [NCOL-1:0]      col_fifo_empty,
  input  logic [NCOL*MW-1:0]   col_fifo_out,
  output logic [NCOL-1:0]      col_rden,
  output logic [MW-1:0]        move_out,
  output logic [2:0]           move_col,
  output logic                 move_valid,
  input  logic                 move_ready,
  output logic                 busy,
  output logic                 pass_done,
  output logic                 timeout_err,
  output logic [CW-1:0]        move_count
);

  localparam int TW = $clog2(GEN_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(GEN_TIMEOUT - 1);

  logic [2:0]    state;
  logic          clr_cnt;
  logic [TW-1:0] timer;
  logic [2:0]    ptr;
  logic [2:0]    sel;
  logic          inflight;
  logic          grant_valid;
  logic [2:0]    grant;
  logic          issue;
  logic          consume;

  rr_pick8 u_pick (
    .req         (~col_fifo_empty),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // A read may only start with nothing in flight and the output slot free or
  // being emptied this cycle; a capture cycle always has inflight set.
  assign issue     = (state == ST_DRAIN) && !inflight &&
                     (!move_valid || move_ready) && grant_valid;
  assign consume   = move_valid && move_ready;
  assign col_rden  = issue ? (NCOL'(1) << grant) : '0;
  assign col_reset = (state == ST_CLEAR);
  assign busy      = (state != ST_IDLE);
  assign pass_done = (state == ST_FINISH);

  // Pass sequencing: flush columns, wait for done (or time out), drain, finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state is registered with non-blocking assignments so every
      // decision below sees the values from before this edge.
      state       <= ST_IDLE;
      clr_cnt     <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_CLEAR;
            clr_cnt     <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt) begin
            state <= ST_GEN;
            timer <= '0;
          end else begin
            clr_cnt <= 1'b1;
          end
        end
        ST_GEN: begin
          timer <= timer + 1'b1;
          // Done flags seen in the first GEN cycle may predate the flush.
          if ((timer != '0) && (&col_done)) begin
            state <= ST_DRAIN;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((&col_fifo_empty) && !inflight && !move_valid) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Read issue, one-cycle-later capture, output handshake and move counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      sel        <= '0;
      inflight   <= 1'b0;
      move_out   <= PVOID;
      move_col   <= '0;
      move_valid <= 1'b0;
      move_count <= '0;
    end else begin
      if (issue) begin
        inflight <= 1'b1;
        sel      <= grant;
        ptr      <= grant + 3'd1;
      end
      // Capture wins over consume so a word consumed this cycle is replaced.
      if (inflight) begin
        move_out   <= col_fifo_out[sel*MW +: MW];
        move_col   <= sel;
        move_valid <= 1'b1;
        inflight   <= 1'b0;
      end else if (consume) begin
        move_valid <= 1'b0;
      end
      if ((state == ST_IDLE) && start) begin
        move_count <= '0;
      end else if (consume && (move_count != {CW{1'b1}})) begin
        move_count <= move_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_move_stream_arbiter.sv
// Self-checking bench: a behavioural column model feeds the arbiter, a
// round-robin reference predicts the move stream into a scoreboard, and a
// monitor checks every delivered move plus the pass-level protocol.
module tb_move_stream_arbiter;
  import chess_pkg::*;

  localparam int CW = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                col_reset;
  logic [NCOL-1:0]     col_done;
  logic [NCOL-1:0]     col_fifo_empty;
  logic [NCOL*MW-1:0]  col_fifo_out;
  logic [NCOL-1:0]     col_rden;
  logic [MW-1:0]       move_out;
  logic [2:0]          move_col;
  logic                move_valid;
  logic                move_ready;
  logic                busy;
  logic                pass_done;
  logic                timeout_err;
  logic [CW-1:0]       move_count;

  always #5 clk = ~clk;

  move_stream_arbiter #(.CW(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .col_reset      (col_reset),
    .col_done       (col_done),
    .col_fifo_empty (col_fifo_empty),
    .col_fifo_out   (col_fifo_out),
    .col_rden       (col_rden),
    .move_out       (move_out),
    .move_col       (move_col),
    .move_valid     (move_valid),
    .move_ready     (move_ready),
    .busy           (busy),
    .pass_done      (pass_done),
    .timeout_err    (timeout_err),
    .move_count     (move_count)
  );

  typedef struct {
    logic [2:0]    col;
    logic [MW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [2:0]    seen_cols[$];
  logic [MW-1:0] fifo_q[NCOL][$];
  int            cfg_depth[NCOL];
  logic [7:0]    cfg_mask;
  int            cfg_dly;
  int            model_ptr;
  bit            ready_rand;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] rand_word();
    logic [MW-1:0] w;
    for (int k = 0; k < 5; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Fill the column FIFOs for a pass and predict the drained order: pure
  // round-robin over the queue contents starting at the persistent pointer.
  task automatic load_columns();
    logic [MW-1:0] sh[NCOL][$];
    logic [MW-1:0] w;
    int remaining = 0;
    exp_t e;
    for (int i = 0; i < NCOL; i++) begin
      for (int k = 0; k < cfg_depth[i]; k++) begin
        w = rand_word();
        fifo_q[i].push_back(w);
        sh[i].push_back(w);
        remaining++;
      end
    end
    while (remaining > 0) begin
      for (int off = 0; off < NCOL; off++) begin
        int c = (model_ptr + off) % NCOL;
        if (sh[c].size() > 0) begin
          e.col  = 3'(c);
          e.data = sh[c].pop_front();
          sb_q.push_back(e);
          model_ptr = (c + 1) % NCOL;
          remaining--;
          break;
        end
      end
    end
  endtask

  // Column unit model: flush on reset/col_reset, load after the flush,
  // raise done after a delay, and serve reads with one cycle of latency.
  logic [NCOL-1:0] rd_s;
  logic            rst_s;
  logic            loaded;
  int              gcnt;

  always @(negedge clk) begin
    rd_s  <= col_rden;
    rst_s <= col_reset;
  end

  always @(posedge clk) begin
    if (reset || rst_s) begin
      for (int i = 0; i < NCOL; i++) fifo_q[i].delete();
      col_fifo_out   <= '0;
      col_fifo_empty <= '1;
      col_done       <= '0;
      loaded         <= reset ? 1'b1 : 1'b0;
      gcnt           <= 0;
    end else begin
      if (!loaded) begin
        load_columns();
        loaded <= 1'b1;
        gcnt   <= 0;
      end else begin
        if (gcnt < 1000) gcnt <= gcnt + 1;
        if (gcnt == cfg_dly) col_done <= cfg_mask;
      end
      for (int i = 0; i < NCOL; i++) begin
        if (rd_s[i] && fifo_q[i].size() > 0) col_fifo_out[i*MW +: MW] <= fifo_q[i].pop_front();
      end
      for (int i = 0; i < NCOL; i++) col_fifo_empty[i] <= (fifo_q[i].size() == 0);
    end
  end

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (ready_rand) move_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: protocol bookkeeping and scoreboard comparison, sampled mid-cycle.
  int cyc = 0, cr_w = 0, cr_rises = 0, rden_total = 0, pd_cnt = 0;
  int gen_start_cyc = 0, first_rden_cyc = 0;
  bit cr_prev = 0, rden_pending = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      cr_prev      = 0;
      cr_w         = 0;
      rden_pending = 0;
    end else begin
      if (col_reset) begin
        if (!cr_prev) cr_rises++;
        cr_w++;
      end else if (cr_prev) begin
        check("col_reset_width", cr_w, 2);
        cr_w          = 0;
        gen_start_cyc = cyc;
        rden_pending  = 1;
      end
      cr_prev = col_reset;
      if (col_rden != '0) begin
        rden_total++;
        if (rden_pending) begin
          first_rden_cyc = cyc;
          rden_pending   = 0;
        end
        check("rden_onehot", $onehot(col_rden), 1);
        check("rden_on_empty", |(col_rden & col_fifo_empty), 0);
        check("rden_outside_drain", col_reset || !busy, 0);
      end
      if (pass_done) pd_cnt++;
      if (move_valid && move_ready) begin
        seen_cols.push_back(move_col);
        if (sb_q.size() == 0) begin
          check("unexpected_move", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("move_col", move_col, e.col);
          check("move_out", move_out, e.data);
        end
      end
    end
  end

  int b_pd, b_cr, b_rden;

  task automatic set_depths(input int d0, d1, d2, d3, d4, d5, d6, d7);
    cfg_depth[0] = d0; cfg_depth[1] = d1; cfg_depth[2] = d2; cfg_depth[3] = d3;
    cfg_depth[4] = d4; cfg_depth[5] = d5; cfg_depth[6] = d6; cfg_depth[7] = d7;
  endtask

  task automatic start_pass();
    b_pd   = pd_cnt;
    b_cr   = cr_rises;
    b_rden = rden_total;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_pass(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (pass_done) begin
        ok = 1;
        break;
      end
    end
    check("pass_finished", ok, 1);
    @(negedge clk);
    check("pass_done_one_cycle", pass_done, 0);
    check("busy_after_pass", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_cond_valid_rden(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (move_valid && (col_rden != '0)) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (move_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col_reset"}, col_reset, 0);
    check({tag, "_col_rden"}, col_rden, 0);
    check({tag, "_move_out"}, move_out, 0);
    check({tag, "_move_col"}, move_col, 0);
    check({tag, "_move_valid"}, move_valid, 0);
    check({tag, "_pass_done"}, pass_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_move_count"}, move_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] hold;
    bit   ok;
    int   total;
    logic [2:0] order3[6];
    order3[0] = 3'd0; order3[1] = 3'd3; order3[2] = 3'd7;
    order3[3] = 3'd0; order3[4] = 3'd7; order3[5] = 3'd7;

    reset = 1'b1; start = 1'b0; move_ready = 1'b1; ready_rand = 1'b0;
    set_depths(0, 0, 0, 0, 0, 0, 0, 0);
    cfg_mask = 8'hFF; cfg_dly = 5; model_ptr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("por");

    // All FIFOs empty, all done: a pass with no moves.
    set_depths(0, 0, 0, 0, 0, 0, 0, 0);
    cfg_mask = 8'hFF; cfg_dly = 5;
    start_pass();
    wait_pass(500);
    check("empty_rden_count", rden_total - b_rden, 0);
    check("empty_col_reset_pulses", cr_rises - b_cr, 1);
    check("empty_pass_done", pd_cnt - b_pd, 1);
    check("empty_move_count", move_count, 0);
    check("empty_timeout_err", timeout_err, 0);

    // Uneven depths, no backpressure: fixed round-robin order.
    set_depths(2, 0, 0, 1, 0, 0, 0, 3);
    cfg_dly = 2;
    seen_cols.delete();
    start_pass();
    wait_pass(500);
    check("rr_moves_seen", seen_cols.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < seen_cols.size()) check("rr_order", seen_cols[i], order3[i]);
    end
    check("rr_move_count", move_count, 6);
    check("rr_pass_done", pd_cnt - b_pd, 1);
    check("rr_sb_drained", sb_q.size(), 0);

    // Reset in the middle of a drain.
    set_depths(3, 3, 0, 2, 0, 0, 1, 0);
    start_pass();
    wait_cond_valid_rden(500, ok);
    check("middrain_reached", ok, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb_q.delete();
    model_ptr = 0;
    @(negedge clk);
    check_reset_state("middrain");
    @(posedge clk); #1;

    // Backpressure: first move held for 10 cycles, then the second follows.
    set_depths(0, 0, 2, 0, 0, 0, 0, 0);
    move_ready = 1'b0;
    start_pass();
    wait_valid(500, ok);
    check("bp_first_valid", ok, 1);
    hold = move_out;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_move_stable", move_out, hold);
      check("bp_valid_held", move_valid, 1);
      check("bp_no_rden", col_rden, 0);
    end
    @(posedge clk); #1 move_ready = 1'b1;
    wait_pass(500);
    check("bp_move_count", move_count, 2);
    check("bp_sb_drained", sb_q.size(), 0);

    // Column 4 never reports done: drain is forced after the timeout.
    total = 0;
    for (int i = 0; i < NCOL; i++) begin
      cfg_depth[i] = $urandom_range(0, 3);
      total += cfg_depth[i];
    end
    if (cfg_depth[1] == 0) begin
      cfg_depth[1] = 2;
      total += 2;
    end
    cfg_mask = 8'hEF; cfg_dly = 3;
    start_pass();
    wait_pass(500);
    check("to_drain_entry_cycles", first_rden_cyc - gen_start_cyc, GEN_TIMEOUT);
    check("to_timeout_err", timeout_err, 1);
    check("to_move_count", move_count, total);
    check("to_sb_drained", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", timeout_err, 1);

    // Ignored starts mid-pass, and the move counter saturating.
    set_depths(129, 129, 129, 129, 129, 129, 128, 128);
    cfg_mask = 8'hFF; cfg_dly = 4;
    ready_rand = 1'b1;
    start_pass();
    @(negedge clk);
    check("sat_err_cleared_on_start", timeout_err, 0);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!col_reset) begin
        ok = 1;
        break;
      end
    end
    check("sat_reached_gen", ok, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(500, ok);
    check("sat_first_valid", ok, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_pass(20000);
    check("sat_col_reset_pulses", cr_rises - b_cr, 1);
    check("sat_pass_done", pd_cnt - b_pd, 1);
    check("sat_move_count", move_count, {CW{1'b1}});
    check("sat_sb_drained", sb_q.size(), 0);

    // Random depths with random backpressure.
    for (int p = 0; p < 3; p++) begin
      total = 0;
      for (int i = 0; i < NCOL; i++) begin
        cfg_depth[i] = $urandom_range(0, 6);
        total += cfg_depth[i];
      end
      cfg_dly = $urandom_range(1, 10);
      start_pass();
      wait_pass(2000);
      check("rand_move_count", move_count, total);
      check("rand_sb_drained", sb_q.size(), 0);
      check("rand_timeout_err", timeout_err, 0);
    end
    ready_rand = 1'b0;
    move_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
